// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

   localparam int FRAME_DATA_BITS = 8;
   localparam int TIMEOUT_CYC_DEF = 200000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings ps2_clk/ps2_data into the clk domain and strobes on PS/2 clock falls.
// Synchronizers reset to 1 (bus idle level) so reset release never looks like an edge.
module ps2_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_sync,
   output logic fall_edge
);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
   logic                   clk_prev_q, clk_prev_d;

   // Shift raw pins into the synchronizer chains; keep last synchronized clock level.
   always_comb begin
      clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_d = clk_sync_q[SYNC_STAGES-1];
   end

   // Synchronizer and edge-history registers, preset to the idle-high bus level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         clk_prev_q <= clk_prev_d;
      end
   end

   assign fall_edge = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign data_sync = dat_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Keeps the last four scan bytes in keycode (newest in [7:0]).
// Optional macro PS2_PARITY_CHECK_EN: when defined, bad-parity frames are rejected;
// otherwise the parity bit is sampled but only the stop bit decides validity.
module ps2_keycode_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] keycode,
   output logic        new_byte,
   output logic        frame_err
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int BW = $clog2(FRAME_DATA_BITS);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_DATA_BITS - 1);
`ifdef PS2_PARITY_CHECK_EN
   localparam logic PARITY_IGNORE = 1'b0;
`else
   localparam logic PARITY_IGNORE = 1'b1;
`endif

   logic                       data_sync, fall_edge;
   ps2_state_e                 state_q, state_d;
   logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
   logic [FRAME_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                       par_q, par_d;
   logic [TW-1:0]              tmo_q, tmo_d;
   logic [31:0]                keycode_q, keycode_d;
   logic                       new_byte_q, new_byte_d;
   logic                       frame_err_q, frame_err_d;
   logic                       par_ok, frame_ok;

   ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .data_sync (data_sync),
      .fall_edge (fall_edge)
   );

   // Frame FSM, shift register, timeout and output pulse generation.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      keycode_d   = keycode_q;
      new_byte_d  = 1'b0;
      frame_err_d = 1'b0;
      par_ok      = ^{shreg_q, par_q};
      frame_ok    = data_sync & (par_ok | PARITY_IGNORE);

      if (fall_edge || state_q == ST_IDLE) tmo_d = '0;
      else                                 tmo_d = tmo_q + TW'(1);

      if (fall_edge) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!data_sync) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  shreg_d   = '0;
               end
            end
            ST_DATA: begin
               shreg_d   = {data_sync, shreg_q[FRAME_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BW'(1);
               if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = data_sync;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (frame_ok) begin
                  keycode_d  = {keycode_q[23:0], shreg_q};
                  new_byte_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
         // A stalled keyboard: drop the partial byte so the next start bit is seen.
         state_d     = ST_IDLE;
         tmo_d       = '0;
         frame_err_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         keycode_q   <= '0;
         new_byte_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         tmo_q       <= tmo_d;
         keycode_q   <= keycode_d;
         new_byte_q  <= new_byte_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign keycode   = keycode_q;
   assign new_byte  = new_byte_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: each driven frame pushes its expected
// outcome; a monitor pops and compares on every new_byte/frame_err pulse.
module tb_ps2_keycode_rx;

   localparam int TMO  = 64;
   localparam int HALF = 8;

   typedef struct {
      bit          is_err;
      logic [31:0] kc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] keycode;
   logic        new_byte, frame_err;

   exp_t        exp_q[$];
   logic [31:0] kc_model = '0;
   int          checks = 0;
   int          errors = 0;

   ps2_keycode_rx #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keycode   (keycode),
      .new_byte  (new_byte),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Monitor: every pulse must match the oldest expectation, exactly one cycle wide.
   always @(negedge clk) begin
      if (new_byte && frame_err) begin
         checks++; errors++;
         $display("FAIL both_pulses new_byte=%0b frame_err=%0b required not both", new_byte, frame_err);
      end else if (new_byte || frame_err) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse new_byte=%0b frame_err=%0b keycode=%h", new_byte, frame_err, keycode);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (frame_err !== e.is_err || keycode !== e.kc) begin
               errors++;
               $display("FAIL pulse got err=%0b kc=%h required err=%0b kc=%h", frame_err, keycode, e.is_err, e.kc);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic v);
      ps2_data = v;
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      exp_t e;
      bit   ok;
      logic par;
      par = bad_par ? ^b : ~^b;
`ifdef PS2_PARITY_CHECK_EN
      ok = !bad_stop && !bad_par;
`else
      ok = !bad_stop;
`endif
      if (ok) kc_model = {kc_model[23:0], b};
      e.is_err = !ok;
      e.kc     = kc_model;
      exp_q.push_back(e);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      ps2_bit(bad_stop ? 1'b0 : 1'b1);
      ps2_data = 1'b1;
   endtask

   // Bounded wait for all expected pulses, then check drain and keycode.
   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin cyc(1); n++; end
      cyc(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got %0d outstanding required 0", name, exp_q.size());
      end
      checks++;
      if (keycode !== kc_model) begin
         errors++;
         $display("FAIL %s_keycode got %h required %h", name, keycode, kc_model);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(5);
      checks++;
      if (keycode !== 32'h0 || new_byte !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset got kc=%h nb=%0b fe=%0b required 0 0 0", keycode, new_byte, frame_err);
      end
      rst_n = 1'b1;
      cyc(5);
   endtask

   task automatic test_single();
      send_frame(8'h75, 0, 0);
      drain("single_75");
   endtask

   task automatic test_back_to_back();
      send_frame(8'hF0, 0, 0);
      send_frame(8'h75, 0, 0);
      drain("f0_75");
      checks++;
      if (keycode[15:0] !== 16'hF075) begin
         errors++;
         $display("FAIL f0_75_low got %h required f075", keycode[15:0]);
      end
   endtask

   task automatic test_bad_parity();
      send_frame(8'h22, 1, 0);
      drain("parity_22");
   endtask

   task automatic test_bad_stop();
      send_frame(8'h6B, 0, 1);
      drain("stop_6b");
   endtask

   task automatic test_idle_ones();
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      drain("idle_ones");
   endtask

   task automatic test_timeout();
      exp_t e;
      e.is_err = 1'b1;
      e.kc     = kc_model;
      exp_q.push_back(e);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
      cyc(TMO + 40);
      drain("timeout");
      send_frame(8'h74, 0, 0);
      drain("after_timeout_74");
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b = 8'h5A;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(b[i]);
      ps2_data = b[5];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(3);
      rst_n = 1'b0;
      kc_model = '0;
      cyc(6);
      checks++;
      if (keycode !== 32'h0) begin
         errors++;
         $display("FAIL midframe_reset_kc got %h required 00000000", keycode);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      cyc(4);
      rst_n = 1'b1;
      cyc(30);
      drain("midframe_quiet");
      send_frame(8'h72, 0, 0);
      drain("after_reset_72");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_bad_parity();
      test_bad_stop();
      test_idle_ones();
      test_timeout();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
